chroma_upsampler: RTL and testbench
===================================

# chroma_upsampler

Parametrised 2× horizontal chroma upsampler. It takes one line of decimated even samples for `NUM_CH` channels and emits, per input sample j, the pair (even = x[j], odd = interpolated x[j+½]). Interpolation uses the 6-tap symmetric FIR (21, −52, 159, 159, −52, 21)/256 with rounding, edge replication and output clipping. It sits between the SRAM fetch logic and the colour-space converter, and replaces hand-sequenced U/V shift control with a valid/ready stream.

## Interface
- `DATA_W`, 8: sample width, unsigned.
- `NUM_CH`, 2: independent channels sharing one handshake.
- `LINE_LEN_MAX`, 160: maximum input samples per line.
- `CLOCK_50_I`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `line_len`  in  $clog2(LINE_LEN_MAX+1)  input samples in the coming line; sampled with the line's first sample.
- `mode`  in  1  0 = FIR interpolate, 1 = replicate (odd = even); sampled with the line's first sample.
- `line_abort`  in  1  synchronous flush to IDLE.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  input accepted when both `in_valid` and `in_ready` are high.
- `in_data`  in  NUM_CH·DATA_W  channel c in bits [c·DATA_W +: DATA_W].
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  downstream accepts the pair.
- `out_even`  out  NUM_CH·DATA_W  x[j] per channel.
- `out_odd`  out  NUM_CH·DATA_W  interpolated sample per channel.
- `out_last`  out  1  pair is j = N−1 of the line.
- `busy`  out  1  state ≠ IDLE or `out_valid`.

## Operation
- Each channel has a window W[0..5], holding x[j−2..j+3]. The centre sample is W[2].
- **Step** occurs when `step_ok = !out_valid || out_ready`.
- **IDLE:**
  - `in_ready = step_ok && !line_abort`.
  - On accept: all six W entries ← sample; latch N and mode; set shift count k = 0.
  - N = 0 is treated as 1; N > LINE_LEN_MAX is clamped to LINE_LEN_MAX.
  - Go to RUN, or to FLUSH if N = 1.
- **RUN:**
  - `in_ready` follows the same rule as IDLE.
  - Each accept shifts the window (W[i] ← W[i+1], W[5] ← sample) and increments k.
  - After accepting sample N−1, go to FLUSH.
- **FLUSH:**
  - `in_ready = 0`.
  - On each step, shift with W[5] ← W[5] (right-edge replication) and increment k.
  - Exit to IDLE after 3 shifts.
- **Emission:** every shift with k ≥ 3 (count taken after the increment) loads the output register from the post-shift window and sets `out_valid`.
  - This gives exactly N outputs per line.
  - `out_last` = 1 on the final one.
- **FIR:**
  - acc = 21·(W0+W5) − 52·(W1+W4) + 159·(W2+W3) + 128, signed, `ACC_W = DATA_W+10`.
  - odd = acc >>> 8, clipped to [0, 2^DATA_W − 1].
- **Replicate mode:** odd = W[2].
- **Output handshake:** `out_valid` clears when `out_ready` is high and no new emission occurs in that cycle. The output holds stable while `out_valid && !out_ready`.
- **`line_abort`:**
  - Next state is IDLE; `out_valid`, `out_last` and k are cleared.
  - A pending output is dropped.
  - Abort has priority over accept and emission in the same cycle.

## Timing
- Reset values: state IDLE; `out_valid`, `out_last`, `busy` = 0; `out_even`/`out_odd` = 0; W = 0.
- `in_ready` = 1 in the first cycle after reset release.
- Latency: the pair for j appears the cycle after the edge that accepts sample j+3, or after the corresponding FLUSH shift.
- Throughput: 1 sample/cycle in, 1 pair/cycle out. A new line's first sample may be accepted in the cycle after FLUSH ends.
- FLUSH takes 3 cycles when unstalled; `in_ready` is low throughout.
- Backpressure stalls all shifting, including FLUSH. No data is lost or duplicated.
- `in_ready` depends combinationally on `out_ready` and `line_abort` only.

## Structure
- Package `chroma_up_pkg`:
  - coefficients `C0 = 21`, `C1 = 52`, `C2 = 159`, `RND = 128`, `SHIFT = 8`;
  - state enum {IDLE, RUN, FLUSH};
  - function `acc_w(DATA_W)`.
- Sub-module `chroma_up_tap6`: combinational per-channel FIR, clip and mode mux, instantiated `NUM_CH` times in a generate loop.
- The top level holds the FSM, counters, window registers and output register.

## Test plan
- Constant 100 on both channels, N = 8, FIR → 8 pairs with even = odd = 100; `out_last` only on the 8th.
- Ramp 0, 10, 20, …, 150 (N = 16) on ch0 and constant 200 on ch1 → interior (j = 2..12) ch0 odd = 10j+5; ch1 odd = 200 throughout.
- Clipping:
  - line 0,0,255,255,0,0 → j = 2 odd = 255 (raw 317);
  - line 255,255,0,0,255,255 → j = 2 odd = 0 (raw negative).
- N = 1, sample 77 → exactly one pair: even = 77, odd = 77, `out_last` = 1; IDLE again after 3 FLUSH cycles.
- Random `out_ready` (≈40% low) on a 20-sample random line, FIR and replicate → output sequence identical to the unstalled run; data stable while stalled.
- `line_abort` after 5 accepted samples with `out_valid` high → `out_valid` = 0 next cycle; the following N = 8 constant-50 line yields 8 correct pairs.

Source files
------------

// File: rtl/chroma_up_pkg.sv
// Shared constants, state encoding and width helper
// for the 2x horizontal chroma upsampler.
package chroma_up_pkg;

   localparam int C0    = 21;
   localparam int C1    = 52;
   localparam int C2    = 159;
   localparam int RND   = 128;
   localparam int SHIFT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   // Accumulator width: sample width plus headroom
   // for the tap sums and the signed result.
   function automatic int acc_w(input int dw);
      return dw + 10;
   endfunction

endpackage

// File: rtl/chroma_upsampler_if.sv
// Stream interface for the chroma upsampler:
// line control, input samples and output pairs.
interface chroma_upsampler_if #(
   parameter int DATA_W       = 8,
   parameter int NUM_CH       = 2,
   parameter int LINE_LEN_MAX = 160
);
   localparam int LEN_W = $clog2(LINE_LEN_MAX + 1);

   logic [LEN_W-1:0]         line_len;
   logic                     mode;
   logic                     line_abort;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [NUM_CH*DATA_W-1:0] out_even;
   logic [NUM_CH*DATA_W-1:0] out_odd;
   logic                     out_last;
   logic                     busy;

   modport master (
      output line_len, mode, line_abort,
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid,
      input  out_even, out_odd, out_last, busy
   );

   modport slave (
      input  line_len, mode, line_abort,
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid,
      output out_even, out_odd, out_last, busy
   );

endinterface

// File: rtl/chroma_up_tap6.sv
// One channel of the 6-tap half-sample FIR with
// rounding, clipping and replicate-mode bypass.
module chroma_up_tap6 #(
   parameter int DATA_W = 8
) (
   input  logic [5:0][DATA_W-1:0] i_win,
   input  logic                   i_mode,
   output logic [DATA_W-1:0]      o_odd
);
   import chroma_up_pkg::*;

   localparam int ACC_W = acc_w(DATA_W);
   localparam int PAD   = ACC_W - DATA_W;

   localparam logic signed [ACC_W-1:0] K0 =
      ACC_W'(C0);
   localparam logic signed [ACC_W-1:0] K1 =
      ACC_W'(C1);
   localparam logic signed [ACC_W-1:0] K2 =
      ACC_W'(C2);
   localparam logic signed [ACC_W-1:0] KR =
      ACC_W'(RND);
   localparam logic signed [ACC_W-1:0] KMAX =
      ACC_W'((1 << DATA_W) - 1);

   logic signed [ACC_W-1:0] w_s05;
   logic signed [ACC_W-1:0] w_s14;
   logic signed [ACC_W-1:0] w_s23;
   logic signed [ACC_W-1:0] w_acc;
   logic signed [ACC_W-1:0] w_q;

   // Symmetric tap sums, weighted sum, scale, clip.
   always_comb begin
      w_s05 = $signed({{PAD{1'b0}}, i_win[0]})
            + $signed({{PAD{1'b0}}, i_win[5]});
      w_s14 = $signed({{PAD{1'b0}}, i_win[1]})
            + $signed({{PAD{1'b0}}, i_win[4]});
      w_s23 = $signed({{PAD{1'b0}}, i_win[2]})
            + $signed({{PAD{1'b0}}, i_win[3]});
      w_acc = K0 * w_s05 - K1 * w_s14
            + K2 * w_s23 + KR;
      w_q   = w_acc >>> SHIFT;
      o_odd = '0;
      if (i_mode)
         o_odd = i_win[2];
      else if (w_q[ACC_W-1])
         o_odd = '0;
      else if (w_q > KMAX)
         o_odd = '1;
      else
         o_odd = w_q[DATA_W-1:0];
   end

endmodule

// File: rtl/chroma_upsampler.sv
// 2x horizontal chroma upsampler: line FSM, sliding
// window per channel and registered output pair.
module chroma_upsampler #(
   parameter int DATA_W       = 8,
   parameter int NUM_CH       = 2,
   parameter int LINE_LEN_MAX = 160
) (
   input logic               CLOCK_50_I,
   input logic               resetn,
   chroma_upsampler_if.slave bus
);
   import chroma_up_pkg::*;

   localparam int LEN_W = $clog2(LINE_LEN_MAX + 1);
   localparam int K_W   = $clog2(LINE_LEN_MAX + 3);
   localparam int DW    = NUM_CH * DATA_W;

   state_t                          r_state;
   logic [NUM_CH-1:0][5:0][DATA_W-1:0] r_win;
   logic [K_W-1:0]                  r_k;
   logic [K_W-1:0]                  r_n;
   logic                            r_mode;
   logic                            r_out_valid;
   logic                            r_out_last;
   logic [DW-1:0]                   r_even;
   logic [DW-1:0]                   r_odd;

   logic [NUM_CH-1:0][5:0][DATA_W-1:0] w_win_sh;
   logic [NUM_CH-1:0][DATA_W-1:0]   w_odd;
   logic [K_W-1:0]                  w_len;
   logic [K_W-1:0]                  w_k_nxt;
   logic [K_W-1:0]                  w_k_end;
   logic [K_W-1:0]                  w_n_m1;
   logic                            w_step_ok;
   logic                            w_in_ready;
   logic                            w_acc;
   logic                            w_shift;
   logic                            w_emit;

   assign w_step_ok  = !r_out_valid || bus.out_ready;
   assign w_in_ready = (r_state != FLUSH) && w_step_ok
                     && !bus.line_abort;
   assign w_acc      = bus.in_valid && w_in_ready;
   assign w_shift    =
      ((r_state == RUN) && w_acc) ||
      ((r_state == FLUSH) && w_step_ok
       && !bus.line_abort);
   assign w_k_nxt    = r_k + K_W'(1);
   assign w_k_end    = r_n + K_W'(2);
   assign w_n_m1     = r_n - K_W'(1);
   assign w_emit     = w_shift && (w_k_nxt >= K_W'(3));

   // Clamp the requested line length to [1, MAX].
   always_comb begin
      w_len = K_W'(bus.line_len);
      if (w_len == '0)
         w_len = K_W'(1);
      else if (w_len > K_W'(LINE_LEN_MAX))
         w_len = K_W'(LINE_LEN_MAX);
   end

   // Post-shift window; flush replicates the right edge.
   always_comb begin
      w_win_sh = r_win;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int i = 0; i < 5; i++)
            w_win_sh[c][i] = r_win[c][i+1];
         w_win_sh[c][5] = (r_state == FLUSH)
            ? r_win[c][5]
            : bus.in_data[c*DATA_W +: DATA_W];
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      chroma_up_tap6 #(
         .DATA_W (DATA_W)
      ) u_tap (
         .i_win  (w_win_sh[c]),
         .i_mode (r_mode),
         .o_odd  (w_odd[c])
      );
   end

   // Line FSM, window shifting and output register.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_win       <= '0;
         r_k         <= '0;
         r_n         <= K_W'(1);
         r_mode      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_even      <= '0;
         r_odd       <= '0;
      end else if (bus.line_abort) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_last  <= (w_k_nxt == w_k_end);
            for (int c = 0; c < NUM_CH; c++) begin
               r_even[c*DATA_W +: DATA_W] <=
                  w_win_sh[c][2];
               r_odd[c*DATA_W +: DATA_W]  <= w_odd[c];
            end
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
         unique case (r_state)
            IDLE: begin
               if (w_acc) begin
                  for (int c = 0; c < NUM_CH; c++)
                     for (int i = 0; i < 6; i++)
                        r_win[c][i] <=
                           bus.in_data[c*DATA_W +: DATA_W];
                  r_n     <= w_len;
                  r_mode  <= bus.mode;
                  r_k     <= '0;
                  r_state <= (w_len == K_W'(1))
                           ? FLUSH : RUN;
               end
            end
            RUN: begin
               if (w_acc) begin
                  r_win <= w_win_sh;
                  r_k   <= w_k_nxt;
                  if (w_k_nxt == w_n_m1)
                     r_state <= FLUSH;
               end
            end
            FLUSH: begin
               if (w_shift) begin
                  r_win <= w_win_sh;
                  r_k   <= w_k_nxt;
                  if (w_k_nxt == w_k_end)
                     r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign bus.out_even  = r_even;
   assign bus.out_odd   = r_odd;
   assign bus.busy      = (r_state != IDLE) || r_out_valid;

endmodule

// File: tb/tb_chroma_upsampler.sv
// Directed bench for chroma_upsampler: reset, FIR,
// clipping, short lines, backpressure and abort.
module tb_chroma_upsampler;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int stall_viol;

   logic [15:0] tx[$];
   logic [15:0] ge[$];
   logic [15:0] go[$];
   logic        gl[$];
   logic [15:0] re[$];
   logic [15:0] ro[$];

   chroma_upsampler_if #(
      .DATA_W(8), .NUM_CH(2), .LINE_LEN_MAX(160)
   ) bus ();

   chroma_upsampler #(
      .DATA_W(8), .NUM_CH(2), .LINE_LEN_MAX(160)
   ) dut (
      .CLOCK_50_I (clk),
      .resetn     (rst_n),
      .bus        (bus)
   );

   // Sample k of channel c with edge replication.
   function automatic int px(input int k, input int c);
      logic [15:0] v;
      int kk;
      kk = k;
      if (kk < 0) kk = 0;
      if (kk > tx.size() - 1) kk = tx.size() - 1;
      v = tx[kk];
      return int'(v[c*8 +: 8]);
   endfunction

   function automatic int fir(input int j, input int c);
      int a;
      a = 21 * (px(j-2, c) + px(j+3, c))
        - 52 * (px(j-1, c) + px(j+2, c))
        + 159 * (px(j, c) + px(j+1, c)) + 128;
      a = a >>> 8;
      if (a < 0) a = 0;
      if (a > 255) a = 255;
      return a;
   endfunction

   // Streams tx as one line and collects n_out pairs.
   task automatic run_line(input int n_len,
                           input bit md,
                           input int n_out,
                           input int low_pct);
      int idx = 0;
      int cyc = 0;
      logic pst = 1'b0;
      logic [15:0] pe, po;
      logic fire;
      ge.delete(); go.delete(); gl.delete();
      stall_viol = 0;
      bus.line_len = n_len[7:0];
      bus.mode = md;
      while (ge.size() < n_out && cyc < 2000) begin
         @(negedge clk);
         bus.out_ready =
            ($urandom_range(99) >= low_pct);
         bus.in_valid = (idx < tx.size());
         bus.in_data = (idx < tx.size())
                     ? tx[idx] : 16'h0;
         #1;
         if (pst && (!bus.out_valid ||
             bus.out_even !== pe ||
             bus.out_odd !== po))
            stall_viol++;
         pst = bus.out_valid && !bus.out_ready;
         pe = bus.out_even;
         po = bus.out_odd;
         if (bus.out_valid && bus.out_ready) begin
            ge.push_back(bus.out_even);
            go.push_back(bus.out_odd);
            gl.push_back(bus.out_last);
         end
         fire = bus.in_valid && bus.in_ready;
         @(posedge clk);
         if (fire) idx++;
         cyc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      total++;
      if (cyc >= 2000) begin
         bad++;
         $display("FAIL run_timeout got=%0d want=%0d",
                  ge.size(), n_out);
      end
      for (int i = 0; i < 20 && bus.busy; i++)
         @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_line got=%b want=0",
                  bus.busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.line_len = '0;
      bus.mode = 1'b0;
      bus.line_abort = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_out_valid got=%b want=0",
                  bus.out_valid);
      end
      total++;
      if (bus.out_last !== 1'b0) begin
         bad++;
         $display("FAIL rst_out_last got=%b want=0",
                  bus.out_last);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy got=%b want=0",
                  bus.busy);
      end
      total++;
      if (bus.out_even !== 16'h0 ||
          bus.out_odd !== 16'h0) begin
         bad++;
         $display("FAIL rst_data got=%h/%h want=0/0",
                  bus.out_even, bus.out_odd);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_in_ready got=%b want=1",
                  bus.in_ready);
      end
   endtask

   task automatic test_const();
      tx.delete();
      for (int j = 0; j < 8; j++) tx.push_back(16'h6464);
      run_line(8, 1'b0, 8, 0);
      total++;
      if (ge.size() !== 8) begin
         bad++;
         $display("FAIL const_count got=%0d want=8",
                  ge.size());
      end
      for (int j = 0; j < ge.size(); j++) begin
         total++;
         if (ge[j] !== 16'h6464 || go[j] !== 16'h6464 ||
             gl[j] !== (j == 7)) begin
            bad++;
            $display("FAIL const_j%0d got=%h/%h/%b want=6464/6464/%b",
                     j, ge[j], go[j], gl[j], j == 7);
         end
      end
   endtask

   task automatic test_ramp();
      logic [15:0] ve, vo;
      tx.delete();
      for (int j = 0; j < 16; j++)
         tx.push_back({8'd200, 8'(j * 10)});
      run_line(16, 1'b0, 16, 0);
      total++;
      if (ge.size() !== 16) begin
         bad++;
         $display("FAIL ramp_count got=%0d want=16",
                  ge.size());
      end
      for (int j = 0; j < ge.size(); j++) begin
         ve = ge[j];
         vo = go[j];
         total++;
         if (ve !== {8'd200, 8'(j * 10)} ||
             vo[15:8] !== 8'd200 ||
             gl[j] !== (j == 15)) begin
            bad++;
            $display("FAIL ramp_j%0d got=%h/%h/%b want=%h/c8xx/%b",
                     j, ve, vo, gl[j],
                     {8'd200, 8'(j * 10)}, j == 15);
         end
         if (j >= 2 && j <= 12) begin
            total++;
            if (vo[7:0] !== 8'(j * 10 + 5)) begin
               bad++;
               $display("FAIL ramp_odd_j%0d got=%0d want=%0d",
                        j, vo[7:0], j * 10 + 5);
            end
         end
      end
   endtask

   task automatic test_clip();
      tx.delete();
      tx = '{16'h0000, 16'h0000, 16'hFFFF,
             16'hFFFF, 16'h0000, 16'h0000};
      run_line(6, 1'b0, 6, 0);
      total++;
      if (go.size() < 3 || go[2] !== 16'hFFFF) begin
         bad++;
         $display("FAIL clip_high got=%h want=ffff",
                  go.size() > 2 ? go[2] : 16'hxxxx);
      end
      tx = '{16'hFFFF, 16'hFFFF, 16'h0000,
             16'h0000, 16'hFFFF, 16'hFFFF};
      run_line(6, 1'b0, 6, 0);
      total++;
      if (go.size() < 3 || go[2] !== 16'h0000) begin
         bad++;
         $display("FAIL clip_low got=%h want=0000",
                  go.size() > 2 ? go[2] : 16'hxxxx);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.line_len = 8'd1;
      bus.mode = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 16'h4D4D;
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_accept got=%b want=1",
                  bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (bus.in_ready !== 1'b0 ||
             bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_flush%0d got=%b/%b want=0/0",
                     i, bus.in_ready, bus.out_valid);
         end
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_even !== 16'h4D4D ||
          bus.out_odd !== 16'h4D4D ||
          bus.out_last !== 1'b1 ||
          bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_pair got=%b/%h/%h/%b/%b want=1/4d4d/4d4d/1/1",
                  bus.out_valid, bus.out_even,
                  bus.out_odd, bus.out_last,
                  bus.in_ready);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 ||
          bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL single_done got=%b/%b want=0/0",
                  bus.out_valid, bus.busy);
      end
      tx.delete();
      tx.push_back(16'h2121);
      run_line(0, 1'b0, 1, 0);
      total++;
      if (ge.size() !== 1 || ge[0] !== 16'h2121 ||
          go[0] !== 16'h2121 || gl[0] !== 1'b1) begin
         bad++;
         $display("FAIL zero_len got=%0d pairs want=1 of 2121/2121/1",
                  ge.size());
      end
   endtask

   task automatic test_stall(input bit md);
      int e0, e1, o0, o1;
      logic [15:0] ve, vo;
      tx.delete();
      for (int j = 0; j < 20; j++)
         tx.push_back(16'($urandom));
      run_line(20, md, 20, 0);
      total++;
      if (ge.size() !== 20) begin
         bad++;
         $display("FAIL stall_ref_count md=%0d got=%0d want=20",
                  md, ge.size());
      end
      for (int j = 0; j < ge.size(); j++) begin
         ve = ge[j];
         vo = go[j];
         e0 = px(j, 0);
         e1 = px(j, 1);
         o0 = md ? e0 : fir(j, 0);
         o1 = md ? e1 : fir(j, 1);
         total++;
         if (ve !== {8'(e1), 8'(e0)} ||
             vo !== {8'(o1), 8'(o0)}) begin
            bad++;
            $display("FAIL model md=%0d j%0d got=%h/%h want=%h/%h",
                     md, j, ve, vo,
                     {8'(e1), 8'(e0)}, {8'(o1), 8'(o0)});
         end
      end
      re = ge;
      ro = go;
      run_line(20, md, 20, 40);
      total++;
      if (ge.size() !== re.size()) begin
         bad++;
         $display("FAIL stall_count md=%0d got=%0d want=%0d",
                  md, ge.size(), re.size());
      end
      for (int j = 0; j < ge.size() &&
           j < re.size(); j++) begin
         total++;
         if (ge[j] !== re[j] || go[j] !== ro[j]) begin
            bad++;
            $display("FAIL stall_seq md=%0d j%0d got=%h/%h want=%h/%h",
                     md, j, ge[j], go[j], re[j], ro[j]);
         end
      end
      total++;
      if (stall_viol !== 0) begin
         bad++;
         $display("FAIL stall_hold md=%0d got=%0d want=0",
                  md, stall_viol);
      end
   endtask

   task automatic test_abort();
      @(negedge clk);
      bus.line_len = 8'd8;
      bus.mode = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 16'h1010;
      repeat (5) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre got=%b want=1",
                  bus.out_valid);
      end
      bus.out_ready = 1'b0;
      bus.line_abort = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort_in_ready got=%b want=0",
                  bus.in_ready);
      end
      @(posedge clk);
      #1 bus.line_abort = 1'b0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 ||
          bus.out_last !== 1'b0 ||
          bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_post got=%b/%b/%b want=0/0/0",
                  bus.out_valid, bus.out_last, bus.busy);
      end
      tx.delete();
      for (int j = 0; j < 8; j++) tx.push_back(16'h3232);
      run_line(8, 1'b0, 8, 0);
      total++;
      if (ge.size() !== 8) begin
         bad++;
         $display("FAIL abort_next_count got=%0d want=8",
                  ge.size());
      end
      for (int j = 0; j < ge.size(); j++) begin
         total++;
         if (ge[j] !== 16'h3232 || go[j] !== 16'h3232 ||
             gl[j] !== (j == 7)) begin
            bad++;
            $display("FAIL abort_next_j%0d got=%h/%h/%b want=3232/3232/%b",
                     j, ge[j], go[j], gl[j], j == 7);
         end
      end
   endtask

   initial begin
      test_reset();
      test_const();
      test_ramp();
      test_clip();
      test_single();
      test_stall(1'b0);
      test_stall(1'b1);
      test_abort();
      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
